// File: rtl/doorlock_pkg.sv
`default_nettype none
// ============================================================================
// doorlock_pkg : keypad layout, entry FSM encoding and key decode helper
// Rev 1.0
// ============================================================================
package doorlock_pkg;

    localparam int KEY_W    = 12;
    localparam int KEY_STAR = 10;
    localparam int KEY_HASH = 11;

    typedef enum logic {
        IDLE  = 1'b0,
        ENTRY = 1'b1
    } state_t;

    // Index of the set bit; only meaningful for a one-hot vector.
    function automatic logic [3:0] key_index(input logic [KEY_W-1:0] keys);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (keys[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce : 2-flop synchroniser plus stable-vector debounce for the keypad
// Rev 1.0
// ============================================================================
module key_debounce
    import doorlock_pkg::*;
#(
    parameter int DB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] db_key
);

    localparam int             CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES);

    logic [KEY_W-1:0] sync1;
    logic [KEY_W-1:0] sync2;
    logic [KEY_W-1:0] cand;
    logic [CW-1:0]    cnt;

    // The sample that loads a new candidate counts as its first stable cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            cnt    <= '0;
            db_key <= '0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= CNT_ONE;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
                if (cnt == CNT_MAX - CNT_ONE) begin
                    db_key <= cand;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// keypad_entry : keypad front end producing ps_start / ps_num / ps_end framing
// Rev 1.0
// ============================================================================
module keypad_entry
    import doorlock_pkg::*;
#(
    parameter int DB_CYCLES   = 50000,
    parameter int TIMEOUT_CYC = 5000000,
    parameter int MAX_DIGITS  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    output logic             ps_start,
    output logic [3:0]       ps_num,
    output logic             ps_valid,
    output logic             ps_end,
    output logic [2:0]       digit_cnt,
    output logic             busy,
    output logic             err
);

    localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);
    localparam logic [2:0]    CNT_LIMIT = 3'(MAX_DIGITS);
    localparam logic [3:0]    IDX_STAR  = 4'(KEY_STAR);
    localparam logic [3:0]    IDX_HASH  = 4'(KEY_HASH);

    logic [KEY_W-1:0] db_key;
    logic [KEY_W-1:0] db_prev;
    logic             press;
    logic [3:0]       press_idx;

    state_t          state, state_nx;
    logic [TW-1:0]   tmr, tmr_nx;
    logic            start_nx, valid_nx, end_nx, err_nx, busy_nx;
    logic [3:0]      num_nx;
    logic [2:0]      cnt_nx;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .key_in (key_in),
        .db_key (db_key)
    );

    // Only an all-zero to single-key transition is a press; chords never are.
    assign press     = $onehot(db_key) && (db_prev == '0);
    assign press_idx = key_index(db_key);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tmr       <= '0;
            db_prev   <= '0;
            ps_start  <= 1'b0;
            ps_num    <= '0;
            ps_valid  <= 1'b0;
            ps_end    <= 1'b0;
            digit_cnt <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            tmr       <= tmr_nx;
            db_prev   <= db_key;
            ps_start  <= start_nx;
            ps_num    <= num_nx;
            ps_valid  <= valid_nx;
            ps_end    <= end_nx;
            digit_cnt <= cnt_nx;
            busy      <= busy_nx;
            err       <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        start_nx = 1'b0;
        valid_nx = 1'b0;
        end_nx   = 1'b0;
        err_nx   = 1'b0;
        num_nx   = ps_num;
        cnt_nx   = digit_cnt;

        unique case (state)
            IDLE: begin
                tmr_nx = '0;
                if (press && (press_idx == IDX_STAR)) begin
                    start_nx = 1'b1;
                    cnt_nx   = '0;
                    state_nx = ENTRY;
                end
            end
            ENTRY: begin
                // A press in the expiry cycle wins over the timeout.
                if (press) begin
                    tmr_nx = '0;
                    if (press_idx == IDX_STAR) begin
                        start_nx = 1'b1;
                        cnt_nx   = '0;
                    end else if (press_idx == IDX_HASH) begin
                        end_nx   = 1'b1;
                        state_nx = IDLE;
                    end else if (digit_cnt < CNT_LIMIT) begin
                        num_nx   = press_idx;
                        valid_nx = 1'b1;
                        cnt_nx   = digit_cnt + 3'd1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end else if (tmr == TMO_LAST) begin
                    end_nx   = 1'b1;
                    err_nx   = 1'b1;
                    tmr_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    tmr_nx = tmr + TMR_ONE;
                end
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx == ENTRY);
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// tb_keypad_entry : scoreboard bench with a press-level reference model
// Rev 1.0
// ============================================================================
module tb_keypad_entry;

    localparam int DB  = 4;
    localparam int TMO = 100;
    localparam int MAXD = 4;
    localparam int LAT = 2 + DB + 1;

    typedef struct packed {
        logic       s;
        logic       v;
        logic       e;
        logic       r;
        logic [3:0] num;
        logic [2:0] cnt;
        logic       busy;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] key_in = '0;
    logic        ps_start, ps_valid, ps_end, busy, err;
    logic [3:0]  ps_num;
    logic [2:0]  digit_cnt;

    keypad_entry #(
        .DB_CYCLES   (DB),
        .TIMEOUT_CYC (TMO),
        .MAX_DIGITS  (MAXD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .ps_start  (ps_start),
        .ps_num    (ps_num),
        .ps_valid  (ps_valid),
        .ps_end    (ps_end),
        .digit_cnt (digit_cnt),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    ev_t exp_q[$];
    ev_t exp_e, obs_e;
    int  checks = 0;
    int  errors = 0;
    int  t_drive = 0;
    int  last_evt = 0;
    bit  lat_armed = 0;
    bit  lat_done = 0;

    // Reference model: state of the attempt as the keypad user sees it.
    bit       m_entry = 0;
    int       m_cnt = 0;
    bit [3:0] m_num = 0;

    function automatic void push(bit s, bit v, bit e, bit r, bit [3:0] num, int cnt, bit bsy);
        ev_t x;
        x = '{s: s, v: v, e: e, r: r, num: num, cnt: 3'(cnt), busy: bsy};
        exp_q.push_back(x);
    endfunction

    function automatic void model_press(int k);
        if (!m_entry) begin
            if (k == 10) begin
                m_entry = 1;
                m_cnt = 0;
                push(1, 0, 0, 0, m_num, 0, 1);
            end
        end else if (k == 10) begin
            m_cnt = 0;
            push(1, 0, 0, 0, m_num, 0, 1);
        end else if (k == 11) begin
            m_entry = 0;
            push(0, 0, 1, 0, m_num, m_cnt, 0);
        end else if (m_cnt < MAXD) begin
            m_cnt++;
            m_num = 4'(k);
            push(0, 1, 0, 0, m_num, m_cnt, 1);
        end else begin
            push(0, 0, 0, 1, m_num, m_cnt, 1);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k, input int hold, input int gap);
        logic [11:0] one;
        one = 12'd1;
        key_in = one << k;
        t_drive = cyc;
        model_press(k);
        tick(hold);
        key_in = '0;
        tick(gap);
    endtask

    task automatic chord(input logic [11:0] v, input int hold, input int gap);
        key_in = v;
        tick(hold);
        key_in = '0;
        tick(gap);
    endtask

    task automatic idle_timeout();
        if (m_entry) begin
            m_entry = 0;
            push(0, 0, 1, 1, m_num, m_cnt, 0);
        end
        tick(TMO + 30);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({ps_start, ps_valid, ps_end, err, busy, ps_num, digit_cnt} !== '0) begin
            errors++;
            $display("FAIL %s: got start=%0b valid=%0b end=%0b err=%0b busy=%0b num=%0d cnt=%0d, required all zero",
                     name, ps_start, ps_valid, ps_end, err, busy, ps_num, digit_cnt);
        end
    endtask

    initial begin
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (rst && (ps_start || ps_valid || ps_end || err)) begin
                        obs_e = '{s: ps_start, v: ps_valid, e: ps_end, r: err,
                                  num: ps_num, cnt: digit_cnt, busy: busy};
                        if (lat_armed && !lat_done) begin
                            lat_done = 1;
                            checks++;
                            if (cyc - t_drive != LAT) begin
                                errors++;
                                $display("FAIL first_pulse_latency: got %0d cycles, required %0d",
                                         cyc - t_drive, LAT);
                            end
                        end
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_event: got s=%0b v=%0b e=%0b r=%0b num=%0d cnt=%0d busy=%0b, required no event",
                                     obs_e.s, obs_e.v, obs_e.e, obs_e.r, obs_e.num, obs_e.cnt, obs_e.busy);
                        end else begin
                            exp_e = exp_q.pop_front();
                            if (obs_e !== exp_e) begin
                                errors++;
                                $display("FAIL event: got s=%0b v=%0b e=%0b r=%0b num=%0d cnt=%0d busy=%0b, required s=%0b v=%0b e=%0b r=%0b num=%0d cnt=%0d busy=%0b",
                                         obs_e.s, obs_e.v, obs_e.e, obs_e.r, obs_e.num, obs_e.cnt, obs_e.busy,
                                         exp_e.s, exp_e.v, exp_e.e, exp_e.r, exp_e.num, exp_e.cnt, exp_e.busy);
                            end
                            if (exp_e.e && exp_e.r) begin
                                checks++;
                                if ((cyc - last_evt < TMO - 1) || (cyc - last_evt > TMO + 2)) begin
                                    errors++;
                                    $display("FAIL timeout_delay: got %0d idle cycles, required about %0d",
                                             cyc - last_evt, TMO);
                                end
                            end
                        end
                        last_evt = cyc;
                    end
                end
            end
            begin : stimulus
                bit prev_multi;
                tick(3);
                check_zero("reset_state");
                rst = 1'b1;
                tick(3);
                check_zero("post_reset_idle");

                // Basic attempt, with first-pulse latency measured.
                lat_armed = 1;
                press(10, 10, 10);
                press(1, 10, 10);
                press(2, 10, 10);
                press(3, 10, 10);
                press(11, 10, 10);

                // Bounce rejection inside an attempt.
                press(10, 10, 10);
                for (int i = 0; i < 5; i++) begin
                    key_in[5] = 1'b1;
                    tick(2);
                    key_in[5] = 1'b0;
                    tick(2);
                end
                press(5, 10, 10);
                press(11, 10, 10);

                // Overflow past MAX_DIGITS.
                press(10, 10, 10);
                press(9, 10, 10);
                press(8, 10, 10);
                press(7, 10, 10);
                press(6, 10, 10);
                press(5, 10, 10);
                press(11, 10, 10);

                // Timeout, then an ignored digit in IDLE.
                press(10, 10, 10);
                press(4, 10, 10);
                idle_timeout();
                press(3, 10, 10);

                // Chord while '*' is held, then restart.
                press(10, 10, 0);
                key_in = 12'h40C;
                t_drive = cyc;
                tick(10);
                key_in = '0;
                tick(10);
                press(10, 10, 10);
                press(11, 10, 10);

                // Asynchronous reset mid-attempt.
                press(10, 10, 10);
                press(1, 10, 10);
                press(2, 10, 10);
                #2 rst = 1'b0;
                #1 check_zero("async_reset");
                exp_q.delete();
                m_entry = 0;
                m_cnt = 0;
                m_num = 0;
                tick(3);
                rst = 1'b1;
                tick(2);
                press(7, 10, 10);
                press(10, 10, 10);
                press(11, 10, 10);

                // Randomized key sequences.
                prev_multi = 0;
                for (int it = 0; it < 40; it++) begin
                    int a, b, k;
                    if (!prev_multi && $urandom_range(0, 9) == 0) begin
                        a = $urandom_range(0, 11);
                        b = (a + 1 + $urandom_range(0, 10)) % 12;
                        chord((12'd1 << a) | (12'd1 << b), $urandom_range(8, 14), $urandom_range(8, 14));
                        prev_multi = 1;
                    end else begin
                        a = $urandom_range(0, 15);
                        k = (a < 10) ? a : ((a < 13) ? 10 : 11);
                        press(k, $urandom_range(8, 14), $urandom_range(8, 14));
                        prev_multi = 0;
                    end
                end
                if (m_entry) press(11, 10, 10);

                for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL drain: got %0d events outstanding, required 0", exp_q.size());
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        join_any
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Front-end driver for the doorlock password-entry interface: turns raw keypad buttons into the ps_start / ps_num / ps_end sequence that the doorlock state machine consumes.
- Synchronises and debounces 12 keys (digits 0-9, '*', '#').
- Detects clean single-key presses.
- Runs an entry FSM that frames each password attempt with a start pulse and an end pulse, with one digit pulse per key.
- Sits between the board keypad pins and the doorlock top level, on the same clock.

Parameters:
- DB_CYCLES, 50000, consecutive stable cycles required to accept a new key vector.
- TIMEOUT_CYC, 5000000, idle cycles in ENTRY before the attempt is force-terminated.
- MAX_DIGITS, 6, maximum digits per attempt; further digits are rejected.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- key_in  input  12  raw key levels, active-high; bit d = digit d (0-9), bit 10 = '*', bit 11 = '#'.
- ps_start  output  1  one-cycle pulse: new attempt begins.
- ps_num  output  4  last accepted digit, held until the next digit or reset.
- ps_valid  output  1  one-cycle pulse: ps_num was updated this cycle.
- ps_end  output  1  one-cycle pulse: attempt finished (by '#' or timeout).
- digit_cnt  output  3  digits accepted in the current attempt.
- busy  output  1  high while in ENTRY.
- err  output  1  one-cycle pulse on digit overflow or timeout.

Behaviour:
- Reset: one clock, clk; rst is asynchronous and active-low. While rst=0, all outputs are 0, the FSM is in IDLE, and all counters and sync flops are 0. Reset mid-attempt aborts silently: no ps_end is emitted.
- Synchroniser: 2-flop synchroniser on all 12 key_in bits.
- Debounce: the counter restarts whenever the synchronised vector differs from the candidate vector. When the candidate has been stable for DB_CYCLES cycles, it is copied to db_key.
  - Counter width is $clog2(DB_CYCLES+1).
- Press event: db_key changes from all-zero to exactly one bit set. A multi-bit vector produces no event. No further event is accepted until db_key returns to all-zero.
- Output timing: all outputs are registered. A pulse asserts in the cycle after db_key updates. Latency from key_in change to pulse = 2 + DB_CYCLES + 1 cycles.
- FSM states: IDLE, ENTRY.
  - IDLE + '*' press: ps_start=1 for 1 cycle, digit_cnt<=0, go to ENTRY.
  - IDLE + digit or '#' press: ignored; no output change.
  - ENTRY + digit press with digit_cnt<MAX_DIGITS: ps_num<=digit, ps_valid=1 for 1 cycle, digit_cnt+1.
  - ENTRY + digit press with digit_cnt==MAX_DIGITS: ps_num unchanged, err=1 for 1 cycle, stay in ENTRY.
  - ENTRY + '#' press: ps_end=1 for 1 cycle, go to IDLE. digit_cnt holds its value until the next ps_start.
  - ENTRY + '*' press: restart. ps_start=1 for 1 cycle, digit_cnt<=0, stay in ENTRY; no ps_end.
  - ENTRY, no press for TIMEOUT_CYC cycles: ps_end=1 and err=1 in the same cycle, go to IDLE.
- Timeout counter: reloads on ps_start and on every accepted press, including rejected overflow digits. Width is $clog2(TIMEOUT_CYC+1).
- Pulse exclusivity: at most one of ps_start / ps_valid / ps_end asserts per cycle, because press events are single.
- Timeout vs press: if timeout expiry and a press event fall in the same cycle, the press wins and the counter reloads.
- busy = (state==ENTRY), registered.

Decomposition:
- Shared package doorlock_pkg holds:
  - key index constants: KEY_STAR=10, KEY_HASH=11;
  - state encoding: IDLE=1'b0, ENTRY=1'b1;
  - keypad width constant KEY_W=12.
- One sub-module, key_debounce: 2-flop sync plus stable counter, parameter DB_CYCLES, outputs db_key[11:0]. The entry FSM, edge detection and timeout stay in keypad_entry.

Test Plan (DB_CYCLES=4, TIMEOUT_CYC=100, MAX_DIGITS=4):
- Basic attempt: press and release '*', 1, 2, 3, '#', each held 10 cycles.
  -> ps_start, then ps_valid with ps_num 1, 2, 3, then ps_end; digit_cnt=3; busy falls with ps_end.
  -> First pulse arrives exactly 7 cycles after key_in rises.
- Bounce rejection: toggle key_in[5] every 2 cycles for 20 cycles inside an attempt, then hold for 10.
  -> Exactly one ps_valid with ps_num=5.
- Overflow: '*' then digits 9, 8, 7, 6, 5.
  -> Four ps_valid pulses; fifth press gives err=1 only; ps_num stays 6; digit_cnt=4.
- Timeout: '*', digit 4, then no keys for 100 cycles.
  -> ps_end and err pulse together on the same cycle; FSM back in IDLE; a subsequent digit press gives no output.
- Multi-key and restart: '*' held, then key_in[2] and key_in[3] pressed together.
  -> No event. Then '*' again -> second ps_start, digit_cnt=0, no ps_end.
- Async reset mid-entry: drop rst during ENTRY after 2 digits.
  -> All outputs 0 immediately, without waiting for a clk edge.
  -> After release, digits are ignored until '*'.
